// File: rtl/pbit_pkg.sv
// Shared constants and state encoding for the p-bit local-field accumulator.
package pbit_pkg;

    localparam int FIELD_BITS = 6;
    localparam int FIELD_FRAC = 2;
    localparam int FIELD_MAX  = 31;
    localparam int FIELD_MIN  = -32;

    // IDLE: wait for start | ACCUM: add terms | SAT: clip to field | OUT: present field
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2,
        OUT   = 2'd3
    } pbit_state_e;

    localparam logic SPIN_POS = 1'b1;
    localparam logic SPIN_NEG = 1'b0;

endpackage

// File: rtl/pbit_sat_add.sv
// Signed add of two IN_BITS operands, saturated to a signed OUT_BITS result with a clamp flag.
module pbit_sat_add #(
    parameter int IN_BITS  = 10,
    parameter int OUT_BITS = 10
) (
    input  logic signed [IN_BITS-1:0]  i_a,
    input  logic signed [IN_BITS-1:0]  i_b,
    output logic signed [OUT_BITS-1:0] o_sum,
    output logic                       o_clamp
);

    // Limits expressed at the one-bit-wider sum width so the compare is exact.
    localparam logic signed [IN_BITS:0] MAX_V =
        {{(IN_BITS-OUT_BITS+2){1'b0}}, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [IN_BITS:0] MIN_V = ~MAX_V;

    logic signed [IN_BITS:0] w_sum;

    always_comb begin
        w_sum   = {i_a[IN_BITS-1], i_a} + {i_b[IN_BITS-1], i_b};
        o_sum   = w_sum[OUT_BITS-1:0];
        o_clamp = 1'b0;
        if (w_sum > MAX_V) begin
            o_sum   = MAX_V[OUT_BITS-1:0];
            o_clamp = 1'b1;
        end else if (w_sum < MIN_V) begin
            o_sum   = MIN_V[OUT_BITS-1:0];
            o_clamp = 1'b1;
        end
    end

endmodule

// File: rtl/pbit_field_accum.sv
// Serial local-field builder: bias + sum(+/-w), saturated to s[3].[2] for fast_tanh.
// Optional macro PBIT_BETA_SHIFT_EN adds beta_shift (field scaled by 1/2/4/8 before clipping).
module pbit_field_accum
    import pbit_pkg::*;
#(
    parameter int WEIGHT_BITS = 6,
    parameter int BIAS_BITS   = 6,
    parameter int ACC_BITS    = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_valid,
    output logic                          start_ready,
    input  logic signed [BIAS_BITS-1:0]   start_bias,
    input  logic                          start_empty,
`ifdef PBIT_BETA_SHIFT_EN
    input  logic [1:0]                    beta_shift,
`endif
    input  logic                          term_valid,
    output logic                          term_ready,
    input  logic signed [WEIGHT_BITS-1:0] term_weight,
    input  logic                          term_spin,
    input  logic                          term_last,
    output logic                          field_valid,
    input  logic                          field_ready,
    output logic signed [FIELD_BITS-1:0]  field_out,
    output logic                          acc_clamped
);

    pbit_state_e r_state, w_state_nxt;

    logic signed [ACC_BITS-1:0]    r_acc;
    logic signed [ACC_BITS-1:0]    w_acc_sum;
    logic                          w_acc_clamp;
    logic                          r_clamped;
    logic signed [FIELD_BITS-1:0]  r_field;
    logic signed [FIELD_BITS-1:0]  w_field_sat;
    logic                          w_field_sat_unused;
    logic signed [WEIGHT_BITS:0]   w_weight_ext;
    logic signed [WEIGHT_BITS:0]   w_addend;
    logic signed [ACC_BITS+2:0]    w_acc_scaled;
    logic                          w_start_acc;
    logic                          w_term_acc;

    assign w_start_acc = start_valid && (r_state == IDLE);
    assign w_term_acc  = term_valid && (r_state == ACCUM);

    // Negation at WEIGHT_BITS+1 so the most-negative weight flips without wrapping.
    assign w_weight_ext = (WEIGHT_BITS+1)'(term_weight);
    assign w_addend     = (term_spin == SPIN_POS) ? w_weight_ext : -w_weight_ext;

    pbit_sat_add #(.IN_BITS(ACC_BITS), .OUT_BITS(ACC_BITS)) u_acc_add (
        .i_a     (r_acc),
        .i_b     (ACC_BITS'(w_addend)),
        .o_sum   (w_acc_sum),
        .o_clamp (w_acc_clamp)
    );

`ifdef PBIT_BETA_SHIFT_EN
    logic [1:0] r_beta;
    assign w_acc_scaled = (ACC_BITS+3)'(r_acc) <<< r_beta;
`else
    assign w_acc_scaled = (ACC_BITS+3)'(r_acc);
`endif

    pbit_sat_add #(.IN_BITS(ACC_BITS+3), .OUT_BITS(FIELD_BITS)) u_field_sat (
        .i_a     (w_acc_scaled),
        .i_b     ('0),
        .o_sum   (w_field_sat),
        .o_clamp (w_field_sat_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        start_ready = 1'b0;
        term_ready  = 1'b0;
        field_valid = 1'b0;
        case (r_state)
            IDLE: begin
                start_ready = !reset;
                if (w_start_acc) w_state_nxt = start_empty ? SAT : ACCUM;
            end
            ACCUM: begin
                term_ready = 1'b1;
                if (w_term_acc && term_last) w_state_nxt = SAT;
            end
            SAT: w_state_nxt = OUT;
            OUT: begin
                field_valid = 1'b1;
                if (field_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_clamped <= 1'b0;
            r_field   <= '0;
`ifdef PBIT_BETA_SHIFT_EN
            r_beta    <= 2'd0;
`endif
        end else begin
            if (w_start_acc) begin
                r_acc     <= ACC_BITS'(start_bias);
                r_clamped <= 1'b0;
`ifdef PBIT_BETA_SHIFT_EN
                r_beta    <= beta_shift;
`endif
            end else if (w_term_acc) begin
                r_acc     <= w_acc_sum;
                r_clamped <= r_clamped | w_acc_clamp;
            end
            if (r_state == SAT) r_field <= w_field_sat;
        end
    end

    assign field_out   = r_field;
    assign acc_clamped = r_clamped;

endmodule

// File: tb/tb_pbit_field_accum.sv
// Directed bench for pbit_field_accum against an integer model of the field rules.
module tb_pbit_field_accum;

    localparam int WB = 6;
    localparam int BB = 6;
    localparam int AB = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start_valid = 1'b0;
    logic                 start_ready;
    logic signed [BB-1:0] start_bias = '0;
    logic                 start_empty = 1'b0;
    logic                 term_valid = 1'b0;
    logic                 term_ready;
    logic signed [WB-1:0] term_weight = '0;
    logic                 term_spin = 1'b0;
    logic                 term_last = 1'b0;
    logic                 field_valid;
    logic                 field_ready = 1'b0;
    logic signed [5:0]    field_out;
    logic                 acc_clamped;
`ifdef PBIT_BETA_SHIFT_EN
    logic [1:0]           beta_shift = 2'd0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int exp_field = 0;
    bit exp_clamp = 1'b0;
    bit chk_en = 1'b0;
    int tw[16];
    bit ts[16];

    always #5 clk = ~clk;

    pbit_field_accum #(.WEIGHT_BITS(WB), .BIAS_BITS(BB), .ACC_BITS(AB)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_bias  (start_bias),
        .start_empty (start_empty),
`ifdef PBIT_BETA_SHIFT_EN
        .beta_shift  (beta_shift),
`endif
        .term_valid  (term_valid),
        .term_ready  (term_ready),
        .term_weight (term_weight),
        .term_spin   (term_spin),
        .term_last   (term_last),
        .field_valid (field_valid),
        .field_ready (field_ready),
        .field_out   (field_out),
        .acc_clamped (acc_clamped)
    );

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Every cycle the field is presented it must match the model.
    always @(negedge clk) begin
        if (chk_en && !reset && field_valid) begin
            check("field_out", int'(field_out), exp_field);
            check("acc_clamped", int'(acc_clamped), int'(exp_clamp));
        end
    end

    function automatic void model(input int bias, input int n, output int f, output bit c);
        int acc;
        int hi;
        int lo;
        acc = bias;
        hi  = (1 << (AB-1)) - 1;
        lo  = -(1 << (AB-1));
        c   = 1'b0;
        for (int k = 0; k < n; k++) begin
            acc = acc + (ts[k] ? tw[k] : -tw[k]);
            if (acc > hi) begin acc = hi; c = 1'b1; end
            else if (acc < lo) begin acc = lo; c = 1'b1; end
        end
        f = (acc > 31) ? 31 : ((acc < -32) ? -32 : acc);
    endfunction

    task automatic set_term(input int k, input int w, input bit s);
        tw[k] = w;
        ts[k] = s;
    endtask

    task automatic do_start(input int bias, input bit empty);
        int cyc;
        start_valid = 1'b1;
        start_bias  = bias[BB-1:0];
        start_empty = empty;
        cyc = 0;
        while (!start_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check("start_ready_wait", int'(start_ready), 1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        start_empty = 1'b0;
    endtask

    task automatic feed_term(input int k, input bit last);
        int cyc;
        term_valid  = 1'b1;
        term_weight = tw[k][WB-1:0];
        term_spin   = ts[k];
        term_last   = last;
        cyc = 0;
        while (!term_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check("term_ready_wait", int'(term_ready), 1);
        @(posedge clk); #1;
        term_valid = 1'b0;
        term_last  = 1'b0;
    endtask

    task automatic run_req(input int bias, input bit empty, input int n, input int hold,
                           input int lit_f, input bit lit_c);
        int f;
        bit c;
        int cyc;
        bit tr_seen;
        model(bias, empty ? 0 : n, f, c);
        check("model_field_pin", f, lit_f);
        check("model_clamp_pin", int'(c), int'(lit_c));
        exp_field = f;
        exp_clamp = c;
        do_start(bias, empty);
        tr_seen = term_ready;
        if (!empty) begin
            for (int k = 0; k < n; k++) begin
                // A stray start while accumulating must be ignored.
                start_valid = 1'b1;
                start_bias  = 6'sd20;
                feed_term(k, k == n-1);
            end
            start_valid = 1'b0;
        end
        cyc = 0;
        while (!field_valid && cyc < 10) begin
            @(posedge clk); #1; cyc++;
            tr_seen = tr_seen | term_ready;
        end
        check("latency_after_accept", cyc, 1);
        if (empty) check("empty_term_ready", int'(tr_seen), 0);
        check("field_lit", int'(field_out), lit_f);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            term_valid  = 1'b1;
            term_weight = 6'sd31;
            term_spin   = 1'b1;
            term_last   = 1'b1;
            check("hold_valid", int'(field_valid), 1);
            check("hold_start_ready", int'(start_ready), 0);
        end
        field_ready = 1'b1;
        @(posedge clk); #1;
        field_ready = 1'b0;
        term_valid  = 1'b0;
        term_last   = 1'b0;
        check("valid_drop", int'(field_valid), 0);
        check("start_ready_back", int'(start_ready), 1);
        check("field_after_hs", int'(field_out), lit_f);
    endtask

    initial begin
        #3;
        check("rst_start_ready", int'(start_ready), 0);
        check("rst_term_ready", int'(term_ready), 0);
        check("rst_field_valid", int'(field_valid), 0);
        check("rst_field_out", int'(field_out), 0);
        check("rst_acc_clamped", int'(acc_clamped), 0);
        #19 reset = 1'b0;
        #1 check("start_ready_after_rst", int'(start_ready), 1);
        @(posedge clk); #1;
        chk_en = 1'b1;

        set_term(0, 3, 1'b1); set_term(1, 2, 1'b0); set_term(2, 5, 1'b1);
        run_req(4, 1'b0, 3, 0, 10, 1'b0);

        set_term(0, 31, 1'b1);
        run_req(28, 1'b0, 1, 0, 31, 1'b0);

        set_term(0, 31, 1'b0);
        run_req(-32, 1'b0, 1, 0, -32, 1'b0);

        run_req(-5, 1'b1, 0, 0, -5, 1'b0);

        set_term(0, 4, 1'b1);
        run_req(27, 1'b0, 1, 0, 31, 1'b0);

        set_term(0, 4, 1'b0);
        run_req(-28, 1'b0, 1, 0, -32, 1'b0);

        set_term(0, -32, 1'b0);
        run_req(0, 1'b0, 1, 1, 31, 1'b0);

        for (int k = 0; k < 5; k++) set_term(k, 31, 1'b1);
        run_req(0, 1'b0, 5, 5, 31, 1'b1);

        for (int k = 0; k < 5; k++) set_term(k, 31, 1'b1);
        for (int k = 5; k < 8; k++) set_term(k, 31, 1'b0);
        set_term(8, 4, 1'b0);
        run_req(0, 1'b0, 9, 2, 30, 1'b1);

        // Reset in the middle of accumulation discards the request.
        set_term(0, 3, 1'b1); set_term(1, 3, 1'b1);
        do_start(7, 1'b0);
        feed_term(0, 1'b0);
        feed_term(1, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("midrst_field_valid", int'(field_valid), 0);
        check("midrst_field_out", int'(field_out), 0);
        check("midrst_term_ready", int'(term_ready), 0);
        @(negedge clk) reset = 1'b0;
        #1 check("midrst_start_ready", int'(start_ready), 1);
        @(posedge clk); #1;

        set_term(0, 1, 1'b1);
        run_req(1, 1'b0, 1, 0, 2, 1'b0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
